// File: rtl/accumulator_sequencer.sv
// Accumulator datapath plus a four-state sequencer that runs the register-file
// read/write traffic for one micro-op at a time over a valid/ready handshake.
module accumulator_sequencer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [1:0]            cmd_reg,
    input  logic [DATA_WIDTH-1:0] cmd_imm,
    output logic [1:0]            register_address,
    input  logic [DATA_WIDTH-1:0] value,
    output logic                  ce_0,
    output logic                  ce_1,
    output logic                  ce_2,
    output logic                  ce_3,
    output logic [DATA_WIDTH-1:0] accumulator_output,
    output logic                  carry,
    output logic                  zero,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WRITE
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LDI  = 3'b001,
        OP_LD   = 3'b010,
        OP_ST   = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_XCHG = 3'b110,
        OP_CLR  = 3'b111
    } op_t;

    state_t                state, state_next;
    op_t                   op_q;
    logic [1:0]            reg_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [DATA_WIDTH-1:0] acc, acc_next;
    logic [DATA_WIDTH-1:0] tmp;
    logic                  carry_q, carry_next;
    logic [DATA_WIDTH:0]   sum;
    logic [3:0]            ce_vec;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= OP_NOP;
            reg_q   <= '0;
            imm_q   <= '0;
            acc     <= '0;
            tmp     <= '0;
            carry_q <= 1'b0;
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            carry_q <= carry_next;
            if (cmd_valid && cmd_ready) begin
                op_q  <= op_t'(cmd_op);
                reg_q <= cmd_reg;
                imm_q <= cmd_imm;
            end
            if (state == READ) begin
                tmp <= value;
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no path through
    // the case statements can leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        done       = 1'b0;
        ce_vec     = 4'b0000;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (op_t'(cmd_op))
                        OP_NOP, OP_LDI, OP_CLR: state_next = EXEC;
                        OP_ST:                  state_next = WRITE;
                        default:                state_next = READ;
                    endcase
                end
            end
            READ:  state_next = (op_q == OP_XCHG) ? WRITE : EXEC;
            EXEC: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            WRITE: begin
                done          = 1'b1;
                ce_vec[reg_q] = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Accumulator and carry only move in EXEC, plus the XCHG swap at the end of WRITE.
    always_comb begin
        acc_next   = acc;
        carry_next = carry_q;
        sum        = {1'b0, acc} + {1'b0, tmp};
        if (state == EXEC) begin
            case (op_q)
                OP_LDI: acc_next = imm_q;
                OP_LD:  acc_next = tmp;
                OP_ADD: {carry_next, acc_next} = sum;
                OP_SUB: begin
                    acc_next   = acc - tmp;
                    carry_next = (acc < tmp);
                end
                OP_CLR: begin
                    acc_next   = '0;
                    carry_next = 1'b0;
                end
                default: acc_next = acc;
            endcase
        end else if (state == WRITE && op_q == OP_XCHG) begin
            acc_next = tmp;
        end
    end

    assign register_address   = reg_q;
    assign accumulator_output = acc;
    assign carry              = carry_q;
    assign zero               = (acc == '0);
    assign ce_0               = ce_vec[0];
    assign ce_1               = ce_vec[1];
    assign ce_2               = ce_vec[2];
    assign ce_3               = ce_vec[3];

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Directed bench for accumulator_sequencer with a behavioural four-entry
// register file attached to its read/write ports.
module tb_accumulator_sequencer;

    localparam logic [2:0] NOP = 3'b000, LDI = 3'b001, LD = 3'b010, ST = 3'b011;
    localparam logic [2:0] ADD = 3'b100, SUB = 3'b101, XCHG = 3'b110, CLR = 3'b111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'b000;
    logic [1:0] cmd_reg = 2'b00;
    logic [7:0] cmd_imm = 8'h00;
    logic [1:0] register_address;
    logic [7:0] value;
    logic       ce_0, ce_1, ce_2, ce_3;
    logic [7:0] accumulator_output;
    logic       carry, zero, done;

    logic [7:0] rf [4] = '{default: 8'h00};

    int n_checks = 0;
    int n_fail   = 0;

    accumulator_sequencer #(.DATA_WIDTH(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_op             (cmd_op),
        .cmd_reg            (cmd_reg),
        .cmd_imm            (cmd_imm),
        .register_address   (register_address),
        .value              (value),
        .ce_0               (ce_0),
        .ce_1               (ce_1),
        .ce_2               (ce_2),
        .ce_3               (ce_3),
        .accumulator_output (accumulator_output),
        .carry              (carry),
        .zero               (zero),
        .done               (done)
    );

    always #5 clk = ~clk;

    assign value = rf[register_address];

    always @(posedge clk) begin
        if (ce_0) rf[0] <= accumulator_output;
        if (ce_1) rf[1] <= accumulator_output;
        if (ce_2) rf[2] <= accumulator_output;
        if (ce_3) rf[3] <= accumulator_output;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("ce_onehot", 32'($countones({ce_3, ce_2, ce_1, ce_0}) <= 1), 32'd1);
    end

    // Issue one command from IDLE (called at posedge+1) and follow it to completion.
    task automatic do_cmd(input logic [2:0] op, input logic [1:0] r, input logic [7:0] imm,
                          input int exp_lat, input logic [7:0] exp_wdata, input bit hold);
        int         cycles;
        int         ce_cycles;
        logic [3:0] ce_v;
        logic [3:0] ce_seen;
        logic [7:0] ce_data;
        bit         is_write;
        is_write  = (op == ST) || (op == XCHG);
        ce_cycles = 0;
        ce_seen   = 4'b0000;
        ce_data   = 8'h00;
        check("idle_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_reg   = r;
        cmd_imm   = imm;
        @(posedge clk); #1;
        cycles    = 1;
        cmd_valid = hold;
        for (;;) begin
            check("busy_ready", 32'(cmd_ready), 32'd0);
            ce_v = {ce_3, ce_2, ce_1, ce_0};
            if (|ce_v) begin
                ce_cycles++;
                ce_seen = ce_seen | ce_v;
                ce_data = accumulator_output;
            end
            if (done || cycles >= 6) break;
            if (hold) begin
                cmd_op  = 3'(cycles + 1);
                cmd_reg = ~r;
                cmd_imm = 8'hC3;
            end
            @(posedge clk); #1;
            cycles++;
        end
        cmd_valid = 1'b0;
        check("latency", 32'(cycles), 32'(exp_lat));
        check("ce_cycles", 32'(ce_cycles), is_write ? 32'd1 : 32'd0);
        check("ce_select", 32'(ce_seen), is_write ? 32'(4'b0001 << r) : 32'd0);
        check("ce_wdata", 32'(ce_data), is_write ? 32'(exp_wdata) : 32'd0);
        @(posedge clk); #1;
        check("post_done", 32'(done), 32'd0);
        check("post_ready", 32'(cmd_ready), 32'd1);
    endtask

    task automatic check_acc(input string tag, input logic [7:0] a, input logic c);
        check({tag, "_acc"}, 32'(accumulator_output), 32'(a));
        check({tag, "_carry"}, 32'(carry), 32'(c));
        check({tag, "_zero"}, 32'(zero), 32'(a == 8'h00));
    endtask

    initial begin
        rst = 1'b1;
        #2;
        check("rst_addr", 32'(register_address), 32'd0);
        check("rst_ce", 32'({ce_3, ce_2, ce_1, ce_0}), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check_acc("rst", 8'h00, 1'b0);
        #6 rst = 1'b0;
        @(posedge clk); #1;

        // LDI then ST r2, read back through LD.
        do_cmd(LDI, 2'd0, 8'h5A, 1, 8'h00, 1'b0);
        check_acc("ldi5a", 8'h5A, 1'b0);
        do_cmd(ST, 2'd2, 8'h00, 1, 8'h5A, 1'b0);
        check("rf2", 32'(rf[2]), 32'h5A);
        do_cmd(LDI, 2'd0, 8'h00, 1, 8'h00, 1'b0);
        do_cmd(LD, 2'd2, 8'h00, 2, 8'h00, 1'b0);
        check_acc("ld_r2", 8'h5A, 1'b0);

        // ADD overflow wraps with carry.
        do_cmd(LDI, 2'd0, 8'hFF, 1, 8'h00, 1'b0);
        do_cmd(ST, 2'd1, 8'h00, 1, 8'hFF, 1'b0);
        do_cmd(LDI, 2'd0, 8'h01, 1, 8'h00, 1'b0);
        do_cmd(ADD, 2'd1, 8'h00, 2, 8'h00, 1'b0);
        check_acc("add_ovf", 8'h00, 1'b1);

        // SUB without and with borrow; LDI and NOP hold carry.
        do_cmd(LDI, 2'd0, 8'h10, 1, 8'h00, 1'b0);
        check_acc("ldi_hold", 8'h10, 1'b1);
        do_cmd(ST, 2'd3, 8'h00, 1, 8'h10, 1'b0);
        do_cmd(LDI, 2'd0, 8'h20, 1, 8'h00, 1'b0);
        do_cmd(SUB, 2'd3, 8'h00, 2, 8'h00, 1'b0);
        check_acc("sub1", 8'h10, 1'b0);
        do_cmd(SUB, 2'd3, 8'h00, 2, 8'h00, 1'b0);
        check_acc("sub2", 8'h00, 1'b0);
        do_cmd(SUB, 2'd3, 8'h00, 2, 8'h00, 1'b0);
        check_acc("sub3", 8'hF0, 1'b1);
        do_cmd(NOP, 2'd0, 8'h77, 1, 8'h00, 1'b0);
        check_acc("nop", 8'hF0, 1'b1);
        do_cmd(CLR, 2'd0, 8'h00, 1, 8'h00, 1'b0);
        check_acc("clr", 8'h00, 1'b0);

        // XCHG swaps acc with r0.
        do_cmd(LDI, 2'd0, 8'h11, 1, 8'h00, 1'b0);
        do_cmd(ST, 2'd0, 8'h00, 1, 8'h11, 1'b0);
        do_cmd(LDI, 2'd0, 8'h22, 1, 8'h00, 1'b0);
        do_cmd(XCHG, 2'd0, 8'h00, 2, 8'h22, 1'b0);
        check_acc("xchg", 8'h11, 1'b0);
        check("rf0", 32'(rf[0]), 32'h22);

        // cmd_valid held with changing ops while busy: only ADD r0 is executed.
        do_cmd(ADD, 2'd0, 8'h00, 2, 8'h00, 1'b1);
        check_acc("hold_add", 8'h33, 1'b0);
        @(posedge clk); #1;
        check_acc("hold_idle", 8'h33, 1'b0);

        // Reset asserted during READ of an ADD.
        cmd_valid = 1'b1;
        cmd_op    = ADD;
        cmd_reg   = 2'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("read_addr", 32'(register_address), 32'd1);
        check("read_ready", 32'(cmd_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("abort_addr", 32'(register_address), 32'd0);
        check("abort_ce", 32'({ce_3, ce_2, ce_1, ce_0}), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        check_acc("abort", 8'h00, 1'b0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("abort_rf1", 32'(rf[1]), 32'hFF);
        do_cmd(LD, 2'd0, 8'h00, 2, 8'h00, 1'b0);
        check_acc("ld_r0", 8'h22, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accumulator_sequencer.md
# accumulator_sequencer

Owns the datapath accumulator and drives the four-entry register file that it writes into. It accepts one micro-op at a time over a valid/ready handshake and runs the register traffic for that op. For reads it presents `register_address` and samples the register file's combinational `value`. For writes it presents `accumulator_output` and pulses exactly one of `ce_0`..`ce_3`. It sits between the instruction decoder and the register file.

## Interface
- DATA_WIDTH, 8, accumulator / register data width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  opcode: 000 NOP, 001 LDI, 010 LD, 011 ST, 100 ADD, 101 SUB, 110 XCHG, 111 CLR
- cmd_reg  in  2  register index for LD/ST/ADD/SUB/XCHG
- cmd_imm  in  DATA_WIDTH  immediate for LDI
- register_address  out  2  read address to register file
- value  in  DATA_WIDTH  register file read data (combinational)
- ce_0, ce_1, ce_2, ce_3  out  1 each  one-hot write enables to register file
- accumulator_output  out  DATA_WIDTH  accumulator contents; register file write data
- carry  out  1  carry/borrow flag
- zero  out  1  high when accumulator == 0
- done  out  1  one-cycle pulse in the final cycle of each command

## Operation
- States: IDLE, READ, EXEC, WRITE.
- IDLE:
  - `cmd_ready`=1.
  - A handshake (`cmd_valid` && `cmd_ready`) latches op, reg and imm.
  - Next state by op: NOP/LDI/CLR → EXEC; LD/ADD/SUB/XCHG → READ; ST → WRITE.
- READ:
  - `register_address` = latched reg.
  - `value` is captured into tmp at the end of the cycle.
  - Next state is EXEC, except XCHG → WRITE.
- EXEC:
  - `done`=1; next state is IDLE.
  - Accumulator update at the end of the cycle:
    - LDI: acc←imm.
    - LD: acc←tmp.
    - ADD: {carry,acc}←acc+tmp, computed at DATA_WIDTH+1 bits.
    - SUB: acc←acc−tmp mod 2^DATA_WIDTH; carry←(acc<tmp), i.e. borrow.
    - CLR: acc←0, carry←0.
    - NOP: no change.
- WRITE:
  - Exactly one `ce_n` is high, with n = latched reg.
  - `accumulator_output` carries the pre-op accumulator.
  - `done`=1; next state is IDLE.
  - XCHG: acc←tmp at the end of WRITE, so the register receives the old acc and the accumulator receives the old register value.
- Carry changes only on ADD, SUB and CLR; every other op holds it.
- `zero` is combinational from acc.
- `register_address` always shows the last latched reg.
- `accumulator_output` is always equal to acc.
- `ce_*` are all 0 outside WRITE. More than one `ce` high at once is illegal.
- `cmd_op`, `cmd_reg` and `cmd_imm` are ignored unless a handshake occurs. The latched copies are stable until the next handshake.

## Timing
- Reset values:
  - state IDLE, acc=0, tmp=0, latched reg=0.
  - `register_address`=0, all `ce_*`=0, `accumulator_output`=0.
  - `carry`=0, `zero`=1, `done`=0, `cmd_ready`=1.
- Latency from the handshake cycle to the `done` cycle:
  - 1 cycle: NOP, LDI, CLR, ST.
  - 2 cycles: LD, ADD, SUB, XCHG.
- Throughput: `cmd_ready` drops the cycle after a handshake. It returns high in the cycle after `done`, which is the first IDLE cycle. Back-to-back commands therefore have at least one idle gap.
- Register file write timing: the write from WRITE is visible on the register file's read port from the cycle after `done`. LD of the same register immediately after ST returns the stored value.
- READ samples `value` combinationally in the same cycle it drives `register_address`.
- Reset asserted mid-command:
  - Return to IDLE immediately (asynchronously).
  - `ce_*` go low without waiting for a clock edge; no `done`.
  - acc, tmp and flags return to reset values.
  - The aborted command has no effect on the register file unless its write edge had already occurred.
- ADD overflow wraps, e.g. 0xFF+0x01 gives acc=0x00, carry=1, zero=1. SUB underflow wraps, e.g. 0x00−0x01 gives acc=0xFF, carry=1.

## Test plan
- Reset, then LDI 0x5A followed by ST r2 → `ce_2` high for exactly one cycle with `accumulator_output`=0x5A; `done` 1 cycle after the ST handshake; r2 later reads 0x5A.
- LDI 0xFF, ST r1, LDI 0x01, ADD r1 → acc=0x00, `carry`=1, `zero`=1; `done` 2 cycles after the ADD handshake.
- LDI 0x10, ST r3, LDI 0x20, SUB r3 → acc=0x10, `carry`=0; then SUB r3 twice → acc=0xF0, `carry`=1.
- With r0=0x11 and acc=0x22, XCHG r0 → `ce_0` pulses with data 0x22; acc=0x11 at `done`; r0 reads 0x22 afterwards.
- Hold `cmd_valid`=1 with changing ops while busy → no extra command is accepted; `cmd_ready`=0 from the cycle after the handshake until `done`; all `ce` remain one-hot or zero on every cycle.
- Assert `rst` during the READ state of ADD → all outputs return to reset values within the same cycle; no `done`; the next LD r0 completes normally.
